// File: rtl/ccip_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ccip_tx_scheduler_if
// Brief    : Producer request bundle and endpoint-facing output of the c1 TX scheduler.
// Revision : 1.0
// ============================================================================
interface ccip_tx_scheduler_if #(
    parameter int NUM_PORTS         = 4,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int RPC_W             = 64
);
    localparam int c_PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]                        req_valid;
    logic [NUM_PORTS-1:0][RPC_W-1:0]             req_data;
    logic [NUM_PORTS-1:0][LMAX_NUM_OF_FLOWS-1:0] req_flow_id;
    logic [NUM_PORTS-1:0]                        req_ready;

    logic [RPC_W-1:0]             rpc_out;
    logic                         rpc_out_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out;
    logic [c_PORT_W-1:0]          rpc_port_out;

    modport master (
        output req_valid, req_data, req_flow_id,
        input  req_ready, rpc_out, rpc_out_valid, rpc_flow_id_out, rpc_port_out
    );

    modport slave (
        input  req_valid, req_data, req_flow_id,
        output req_ready, rpc_out, rpc_out_valid, rpc_flow_id_out, rpc_port_out
    );
endinterface
`default_nettype wire

// File: rtl/ccip_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ccip_tx_scheduler
// Brief    : Round-robin arbiter sharing CCI-P c1 among RPC producers, with almfull slack throttling.
// Revision : 1.0
// ============================================================================
module ccip_tx_scheduler #(
    parameter int NUM_PORTS         = 4,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int ALMFULL_SLACK     = 8,
    parameter int RPC_W             = 64
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           start,
    input  wire logic           sRx_c1TxAlmFull,
    ccip_tx_scheduler_if.slave  bus,
    output logic                throttled,
    output logic [31:0]         grant_cnt,
    output logic [31:0]         throttle_cycles
);
    localparam int         c_PORT_W    = $clog2(NUM_PORTS);
    localparam logic [3:0] c_SLACK     = 4'(ALMFULL_SLACK);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RUN       = 2'd1;
    localparam logic [1:0] c_THROTTLED = 2'd2;

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic                         r_throttled;
    logic [c_PORT_W-1:0]          r_rr_ptr;
    logic [3:0]                   r_slack_cnt;
    logic [3:0]                   w_next_slack;
    logic [RPC_W-1:0]             r_rpc_out;
    logic                         r_rpc_out_valid;
    logic [LMAX_NUM_OF_FLOWS-1:0] r_rpc_flow_id_out;
    logic [c_PORT_W-1:0]          r_rpc_port_out;
    logic [31:0]                  r_grant_cnt;
    logic [31:0]                  r_throttle_cycles;

    logic                         w_found;
    logic [c_PORT_W-1:0]          w_gnt_idx;
    logic [c_PORT_W-1:0]          w_cand;
    int                           w_idx;
    logic                         w_can_grant;
    logic                         w_grant;
    logic [NUM_PORTS-1:0]         w_req_ready;

    // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_PORTS) begin
                w_idx = w_idx - NUM_PORTS;
            end
            w_cand = c_PORT_W'(w_idx);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // FSM output process: grant enable and one-hot ready
    always_comb begin
        w_can_grant = start && (r_state == c_RUN) &&
                      !(sRx_c1TxAlmFull && (r_slack_cnt == c_SLACK));
        w_grant     = w_can_grant && w_found;
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_next_slack = r_slack_cnt;
        if (!sRx_c1TxAlmFull) begin
            w_next_slack = '0;
        end else if (w_grant && (r_slack_cnt != c_SLACK)) begin
            w_next_slack = r_slack_cnt + 4'd1;
        end
    end

    // Throttle decision uses the slack count after this cycle's grant.
    always_comb begin
        w_next_state = r_state;
        if (!start) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:      w_next_state = c_RUN;
                c_RUN:       if (sRx_c1TxAlmFull && (w_next_slack == c_SLACK)) w_next_state = c_THROTTLED;
                c_THROTTLED: if (!sRx_c1TxAlmFull) w_next_state = c_RUN;
                default:     w_next_state = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_throttled <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_throttled <= (w_next_state == c_THROTTLED);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr          <= '0;
            r_slack_cnt       <= '0;
            r_rpc_out         <= '0;
            r_rpc_out_valid   <= 1'b0;
            r_rpc_flow_id_out <= '0;
            r_rpc_port_out    <= '0;
            r_grant_cnt       <= '0;
            r_throttle_cycles <= '0;
        end else begin
            r_slack_cnt     <= w_next_slack;
            r_rpc_out_valid <= w_grant;
            if (w_grant) begin
                r_rpc_out         <= bus.req_data[w_gnt_idx];
                r_rpc_flow_id_out <= bus.req_flow_id[w_gnt_idx];
                r_rpc_port_out    <= w_gnt_idx;
                r_grant_cnt       <= r_grant_cnt + 32'd1;
                r_rr_ptr          <= (w_gnt_idx == c_PORT_W'(NUM_PORTS - 1)) ? '0
                                                                             : w_gnt_idx + c_PORT_W'(1);
            end
            if ((r_state == c_THROTTLED) && (r_throttle_cycles != 32'hFFFF_FFFF)) begin
                r_throttle_cycles <= r_throttle_cycles + 32'd1;
            end
        end
    end

    assign bus.req_ready       = w_req_ready;
    assign bus.rpc_out         = r_rpc_out;
    assign bus.rpc_out_valid   = r_rpc_out_valid;
    assign bus.rpc_flow_id_out = r_rpc_flow_id_out;
    assign bus.rpc_port_out    = r_rpc_port_out;
    assign throttled           = r_throttled;
    assign grant_cnt           = r_grant_cnt;
    assign throttle_cycles     = r_throttle_cycles;
endmodule
`default_nettype wire
